mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of the data bus, MDR and memory data.
REQ-002 SHALL have parameter ADDR_W, default 16 (≤DATA_W): width of MAR and memory address.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2 (≥1): minimum number of cycles in WAIT per access.
REQ-004 SHALL have parameter TIMEOUT, default 255 (>WAIT_CYCLES): cycle count in WAIT at which an access is aborted.
REQ-005 SHALL have ports as follows: Clk  in  1  single clock, all state changes on its rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 BUS_In  in  DATA_W  datapath bus value.
REQ-008 LD_MAR  in  1  load MAR from BUS_In[ADDR_W-1:0].
REQ-009 LD_MDR  in  1  load MDR from BUS_In.
REQ-010 Rd_Req  in  1  start read at MAR.
REQ-011 Wr_Req  in  1  start write of MDR to MAR.
REQ-012 Clr_Err  in  1  clear Err.
REQ-013 Mem_Rdata  in  DATA_W  memory read data.
REQ-014 Mem_Ready  in  1  memory ready.
REQ-015 MAR_Out  out  ADDR_W  MAR contents.
REQ-016 MDR_Out  out  DATA_W  MDR contents.
REQ-017 Mem_Addr  out  ADDR_W  equals MAR.
REQ-018 Mem_Wdata  out  DATA_W  equals MDR.
REQ-019 Mem_CE  out  1  chip enable.
REQ-020 Mem_WE  out  1  write enable.
REQ-021 Busy  out  1  access in progress.
REQ-022 R  out  1  one-cycle access-complete strobe.
REQ-023 Err  out  1  sticky error flag.

Function
REQ-024 SHALL implement states IDLE, WAIT, DONE; IDLE and DONE are request-accepting states.
REQ-025 In accepting states, LD_MAR/LD_MDR SHALL load on the clock edge; LD_MDR has priority over a completing read only when not in WAIT.
REQ-026 In accepting states, exactly one of Rd_Req/Wr_Req SHALL move to WAIT, latch the direction, set wait counter = WAIT_CYCLES-1 and timeout counter = 0.
REQ-027 Rd_Req and Wr_Req both high in an accepting state SHALL start nothing and set Err.
REQ-028 In WAIT: Busy=1, Mem_CE=1, Mem_WE=1 only for writes; the wait counter SHALL decrement and saturate at 0, and the timeout counter SHALL increment each cycle.
REQ-029 In WAIT with wait counter==0 and Mem_Ready=1: read SHALL load MDR from Mem_Rdata; either direction SHALL go to DONE.
REQ-030 In WAIT with timeout counter==TIMEOUT-1 and no completion: SHALL go to DONE, set Err, leave MDR unchanged.
REQ-031 DONE SHALL last one cycle with R=1, Busy=0, Mem_CE=0, then go to IDLE unless a new request starts WAIT (back-to-back).
REQ-032 Rd_Req, Wr_Req, LD_MAR or LD_MDR asserted in WAIT SHALL be ignored and set Err.
REQ-033 Err SHALL be cleared by Clr_Err; a simultaneous set condition wins.
REQ-034 With Mem_Ready held high, a request sampled at edge 0 SHALL give WAIT for cycles 1..WAIT_CYCLES and R=1 in cycle WAIT_CYCLES+1.
REQ-035 Mem_CE, Mem_WE, R and Busy SHALL be decoded from registered state only (glitch-free, no input paths).

Reset
REQ-036 Reset low SHALL immediately force IDLE, MAR=0, MDR=0, counters=0, Err=0, and therefore Mem_CE=Mem_WE=Busy=R=0, regardless of clock.
REQ-037 Reset during WAIT SHALL abort the access with no R pulse and no MDR update.

Verification (DATA_W=16, ADDR_W=16, WAIT_CYCLES=2, TIMEOUT=8)
REQ-038 Read: BUS_In=0x3000+LD_MAR, Rd_Req, Mem_Ready=1, Mem_Rdata=0xBEEF -> Mem_CE high 2 cycles, R in 3rd cycle, MDR_Out=0xBEEF.
REQ-039 Write: MAR=0x0040, MDR=0x1234, Wr_Req -> Mem_WE=Mem_CE=1 for 2 cycles with Mem_Addr=0x0040, Mem_Wdata=0x1234, then R.
REQ-040 Slow memory: Mem_Ready low 5 cycles of WAIT -> R one cycle after Ready rises; Mem_Ready never high -> DONE after 8 WAIT cycles, Err=1, MDR unchanged.
REQ-041 Conflicts: Rd_Req+Wr_Req together -> no access, Err=1; LD_MAR=0xFFFF during WAIT -> MAR unchanged, Err=1; Clr_Err -> Err=0.
REQ-042 Back-to-back: Rd_Req held through DONE -> second WAIT begins immediately, two R pulses 3 cycles apart.
REQ-043 Reset low mid-WAIT -> Mem_CE falls without clock edge, no R, all outputs 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : MAR/MDR memory access sequencer with wait states, timeout
//               abort and a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] BUS_In,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              Rd_Req,
    input  logic              Wr_Req,
    input  logic              Clr_Err,
    input  logic [DATA_W-1:0] Mem_Rdata,
    input  logic              Mem_Ready,
    output logic [ADDR_W-1:0] MAR_Out,
    output logic [DATA_W-1:0] MDR_Out,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_Wdata,
    output logic              Mem_CE,
    output logic              Mem_WE,
    output logic              Busy,
    output logic              R,
    output logic              Err
);

    localparam int c_WCNT_W = $clog2(WAIT_CYCLES + 1);
    localparam int c_TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_WCNT_W-1:0] c_WCNT_INIT = c_WCNT_W'(WAIT_CYCLES - 1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state,  w_state_nx;
    logic [ADDR_W-1:0]   r_mar,    w_mar_nx;
    logic [DATA_W-1:0]   r_mdr,    w_mdr_nx;
    logic [c_WCNT_W-1:0] r_wcnt,   w_wcnt_nx;
    logic [c_TCNT_W-1:0] r_tcnt,   w_tcnt_nx;
    logic                r_write,  w_write_nx;
    logic                r_err,    w_err_nx;
    logic                w_err_set;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_wcnt  <= '0;
            r_tcnt  <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_mar   <= w_mar_nx;
            r_mdr   <= w_mdr_nx;
            r_wcnt  <= w_wcnt_nx;
            r_tcnt  <= w_tcnt_nx;
            r_write <= w_write_nx;
            r_err   <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_mar_nx   = r_mar;
        w_mdr_nx   = r_mdr;
        w_wcnt_nx  = r_wcnt;
        w_tcnt_nx  = r_tcnt;
        w_write_nx = r_write;
        w_err_set  = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (LD_MAR) w_mar_nx = BUS_In[ADDR_W-1:0];
                if (LD_MDR) w_mdr_nx = BUS_In;
                w_state_nx = ST_IDLE;
                if (Rd_Req && Wr_Req) begin
                    w_err_set = 1'b1;
                end else if (Rd_Req || Wr_Req) begin
                    w_state_nx = ST_WAIT;
                    w_write_nx = Wr_Req;
                    w_wcnt_nx  = c_WCNT_INIT;
                    w_tcnt_nx  = '0;
                end
            end
            ST_WAIT: begin
                // Datapath controls are locked out while an access is in flight.
                if (Rd_Req || Wr_Req || LD_MAR || LD_MDR) w_err_set = 1'b1;
                if (r_wcnt != '0) w_wcnt_nx = r_wcnt - 1'b1;
                w_tcnt_nx = r_tcnt + 1'b1;
                if ((r_wcnt == '0) && Mem_Ready) begin
                    if (!r_write) w_mdr_nx = Mem_Rdata;
                    w_state_nx = ST_DONE;
                end else if (r_tcnt == c_TCNT_LAST) begin
                    w_state_nx = ST_DONE;
                    w_err_set  = 1'b1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        if (w_err_set)    w_err_nx = 1'b1;
        else if (Clr_Err) w_err_nx = 1'b0;
        else              w_err_nx = r_err;
    end

    // Strobes come straight from flops so memory controls never glitch.
    assign Busy      = (r_state == ST_WAIT);
    assign Mem_CE    = (r_state == ST_WAIT);
    assign Mem_WE    = (r_state == ST_WAIT) && r_write;
    assign R         = (r_state == ST_DONE);
    assign Err       = r_err;
    assign MAR_Out   = r_mar;
    assign MDR_Out   = r_mdr;
    assign Mem_Addr  = r_mar;
    assign Mem_Wdata = r_mdr;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit with a
//               transaction-level reference model for random accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int WAIT_CYCLES = 2;
    localparam int TIMEOUT     = 8;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [DATA_W-1:0] BUS_In;
    logic              LD_MAR, LD_MDR, Rd_Req, Wr_Req, Clr_Err;
    logic [DATA_W-1:0] Mem_Rdata;
    logic              Mem_Ready;
    logic [ADDR_W-1:0] MAR_Out, Mem_Addr;
    logic [DATA_W-1:0] MDR_Out, Mem_Wdata;
    logic              Mem_CE, Mem_WE, Busy, R, Err;

    int errors = 0;
    int checks = 0;

    mem_access_unit #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .WAIT_CYCLES(WAIT_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .BUS_In   (BUS_In),
        .LD_MAR   (LD_MAR),
        .LD_MDR   (LD_MDR),
        .Rd_Req   (Rd_Req),
        .Wr_Req   (Wr_Req),
        .Clr_Err  (Clr_Err),
        .Mem_Rdata(Mem_Rdata),
        .Mem_Ready(Mem_Ready),
        .MAR_Out  (MAR_Out),
        .MDR_Out  (MDR_Out),
        .Mem_Addr (Mem_Addr),
        .Mem_Wdata(Mem_Wdata),
        .Mem_CE   (Mem_CE),
        .Mem_WE   (Mem_WE),
        .Busy     (Busy),
        .R        (R),
        .Err      (Err)
    );

    always #5 Clk = ~Clk;

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({Mem_CE, Mem_WE, Busy, R, Err} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {Mem_CE, Mem_WE, Busy, R, Err});
        end
        checks++; if ({MAR_Out, MDR_Out} !== 32'h0) begin
            errors++; $display("FAIL reset_regs: got %h want 0", {MAR_Out, MDR_Out});
        end
        Rd_Req = 1'b1;
        tick();
        Rd_Req = 1'b0;
        checks++; if (Busy !== 1'b0) begin
            errors++; $display("FAIL reset_hold_busy: got %b want 0", Busy);
        end
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_read();
        int ce_cycles = 0;
        int r_cycle   = 0;
        BUS_In = 16'h3000; LD_MAR = 1'b1;
        tick();
        LD_MAR = 1'b0;
        checks++; if (MAR_Out !== 16'h3000) begin
            errors++; $display("FAIL read_mar: got %h want 3000", MAR_Out);
        end
        Rd_Req = 1'b1; Mem_Ready = 1'b1; Mem_Rdata = 16'hBEEF;
        tick();
        Rd_Req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (Mem_CE === 1'b1) ce_cycles++;
            if (R === 1'b1 && r_cycle == 0) r_cycle = c;
            if (c == 1) begin
                checks++; if (Mem_Addr !== 16'h3000 || Mem_WE !== 1'b0) begin
                    errors++; $display("FAIL read_bus: got addr=%h we=%b want 3000/0", Mem_Addr, Mem_WE);
                end
            end
            tick();
        end
        checks++; if (ce_cycles != 2 || r_cycle != 3) begin
            errors++; $display("FAIL read_timing: got ce=%0d r_at=%0d want 2/3", ce_cycles, r_cycle);
        end
        checks++; if (MDR_Out !== 16'hBEEF) begin
            errors++; $display("FAIL read_mdr: got %h want beef", MDR_Out);
        end
    endtask

    task automatic test_write();
        int ok_cycles = 0;
        int we_cycles = 0;
        int r_cycle   = 0;
        BUS_In = 16'h0040; LD_MAR = 1'b1;
        tick();
        LD_MAR = 1'b0; BUS_In = 16'h1234; LD_MDR = 1'b1;
        tick();
        LD_MDR = 1'b0;
        Wr_Req = 1'b1; Mem_Ready = 1'b1;
        tick();
        Wr_Req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (Mem_WE === 1'b1) we_cycles++;
            if (Mem_WE === 1'b1 && Mem_CE === 1'b1 && Mem_Addr === 16'h0040 && Mem_Wdata === 16'h1234)
                ok_cycles++;
            if (R === 1'b1 && r_cycle == 0) r_cycle = c;
            tick();
        end
        checks++; if (ok_cycles != 2 || we_cycles != 2 || r_cycle != 3) begin
            errors++; $display("FAIL write_timing: got ok=%0d we=%0d r_at=%0d want 2/2/3", ok_cycles, we_cycles, r_cycle);
        end
        checks++; if (MDR_Out !== 16'h1234) begin
            errors++; $display("FAIL write_mdr: got %h want 1234", MDR_Out);
        end
    endtask

    task automatic test_slow_memory();
        int busy_cnt = 0;
        Rd_Req = 1'b1; Mem_Ready = 1'b0; Mem_Rdata = 16'hA5A5;
        tick();
        Rd_Req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (Busy === 1'b1) busy_cnt++;
            tick();
        end
        Mem_Ready = 1'b1;
        checks++; if (busy_cnt != 5 || Busy !== 1'b1) begin
            errors++; $display("FAIL slow_wait: got busy=%0d/%b want 5/1", busy_cnt, Busy);
        end
        tick();
        Mem_Ready = 1'b0;
        checks++; if (R !== 1'b1 || MDR_Out !== 16'hA5A5 || Err !== 1'b0) begin
            errors++; $display("FAIL slow_done: got r=%b mdr=%h err=%b want 1/a5a5/0", R, MDR_Out, Err);
        end
        tick();
        checks++; if (R !== 1'b0) begin
            errors++; $display("FAIL slow_r_width: got %b want 0", R);
        end
    endtask

    task automatic test_timeout();
        int busy_cnt = 0;
        int r_cycle  = 0;
        Rd_Req = 1'b1; Mem_Ready = 1'b0; Mem_Rdata = 16'h1111;
        tick();
        Rd_Req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (Busy === 1'b1) busy_cnt++;
            if (R === 1'b1 && r_cycle == 0) r_cycle = c;
            tick();
        end
        checks++; if (busy_cnt != TIMEOUT || r_cycle != TIMEOUT + 1) begin
            errors++; $display("FAIL timeout_timing: got busy=%0d r_at=%0d want %0d/%0d", busy_cnt, r_cycle, TIMEOUT, TIMEOUT + 1);
        end
        checks++; if (Err !== 1'b1 || MDR_Out !== 16'hA5A5) begin
            errors++; $display("FAIL timeout_state: got err=%b mdr=%h want 1/a5a5", Err, MDR_Out);
        end
    endtask

    task automatic test_conflict();
        int r_cycle = 0;
        Clr_Err = 1'b1;
        tick();
        Clr_Err = 1'b0;
        checks++; if (Err !== 1'b0) begin
            errors++; $display("FAIL conflict_clr: got %b want 0", Err);
        end
        Rd_Req = 1'b1; Wr_Req = 1'b1;
        tick();
        Rd_Req = 1'b0; Wr_Req = 1'b0;
        checks++; if (Busy !== 1'b0 || Err !== 1'b1) begin
            errors++; $display("FAIL conflict_both: got busy=%b err=%b want 0/1", Busy, Err);
        end
        Clr_Err = 1'b1;
        tick();
        Clr_Err = 1'b0;
        Rd_Req = 1'b1; Mem_Ready = 1'b0;
        tick();
        Rd_Req = 1'b0; BUS_In = 16'hFFFF; LD_MAR = 1'b1;
        tick();
        LD_MAR = 1'b0;
        checks++; if (MAR_Out !== 16'h0040 || Err !== 1'b1 || Busy !== 1'b1) begin
            errors++; $display("FAIL conflict_ldmar: got mar=%h err=%b busy=%b want 0040/1/1", MAR_Out, Err, Busy);
        end
        Clr_Err = 1'b1; LD_MDR = 1'b1;
        tick();
        Clr_Err = 1'b0; LD_MDR = 1'b0;
        checks++; if (Err !== 1'b1 || MDR_Out !== 16'hA5A5) begin
            errors++; $display("FAIL conflict_setwins: got err=%b mdr=%h want 1/a5a5", Err, MDR_Out);
        end
        Mem_Ready = 1'b1;
        for (int c = 0; c < 10 && r_cycle == 0; c++) begin
            if (R === 1'b1) r_cycle = c + 1;
            else tick();
        end
        Mem_Ready = 1'b0; Clr_Err = 1'b1;
        tick();
        Clr_Err = 1'b0;
        checks++; if (r_cycle != 2 || Err !== 1'b0) begin
            errors++; $display("FAIL conflict_finish: got r_at=%0d err=%b want 2/0", r_cycle, Err);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0, r1 = 0, r2 = 0;
        Mem_Ready = 1'b1; Mem_Rdata = 16'h1357; Rd_Req = 1'b1;
        tick();
        for (int c = 1; c <= 10; c++) begin
            if (c == 4) begin Rd_Req = 1'b0; Mem_Rdata = 16'h2468; end
            if (R === 1'b1) begin
                if (n == 0) r1 = c;
                else if (n == 1) r2 = c;
                n++;
            end
            if (c == 3) begin
                checks++; if (MDR_Out !== 16'h1357) begin
                    errors++; $display("FAIL b2b_first_mdr: got %h want 1357", MDR_Out);
                end
            end
            tick();
        end
        Mem_Ready = 1'b0;
        checks++; if (n != 2 || r1 != 3 || r2 != 6) begin
            errors++; $display("FAIL b2b_pulses: got n=%0d at %0d,%0d want 2 at 3,6", n, r1, r2);
        end
        checks++; if (MDR_Out !== 16'h2468 || Err !== 1'b1) begin
            errors++; $display("FAIL b2b_state: got mdr=%h err=%b want 2468/1", MDR_Out, Err);
        end
    endtask

    // Reference model: completion lands on the first WAIT cycle that is both
    // past the minimum wait and sees Ready; if that is past TIMEOUT the access
    // aborts at cycle TIMEOUT with Err set.
    task automatic test_random();
        logic [15:0] addr, wdata, rdata, model_mdr;
        logic        is_wr, tmo;
        int          ld, rdy_at, k, busy_cnt, done_c, bad;
        model_mdr = 16'h0;
        for (int i = 0; i < 30; i++) begin
            addr   = 16'($urandom);
            wdata  = 16'($urandom);
            rdata  = 16'($urandom);
            is_wr  = 1'($urandom_range(0, 1));
            ld     = (i == 0 || is_wr) ? 1 : int'($urandom_range(0, 1));
            rdy_at = int'($urandom_range(1, 11));

            Clr_Err = 1'b1; LD_MAR = 1'b1; BUS_In = addr;
            tick();
            Clr_Err = 1'b0; LD_MAR = 1'b0;
            if (ld != 0) begin
                LD_MDR = 1'b1; BUS_In = wdata;
                tick();
                LD_MDR = 1'b0;
                model_mdr = wdata;
            end

            k   = (rdy_at > WAIT_CYCLES) ? rdy_at : WAIT_CYCLES;
            tmo = (k > TIMEOUT);
            if (tmo) k = TIMEOUT;
            if (!is_wr && !tmo) model_mdr = rdata;

            Mem_Rdata = rdata; Mem_Ready = 1'b0;
            Rd_Req = ~is_wr; Wr_Req = is_wr;
            tick();
            Rd_Req = 1'b0; Wr_Req = 1'b0;
            busy_cnt = 0; done_c = 0; bad = 0;
            for (int c = 1; c <= TIMEOUT + 4 && done_c == 0; c++) begin
                Mem_Ready = (c >= rdy_at);
                if (R === 1'b1) begin
                    done_c = c;
                end else begin
                    if (Busy === 1'b1) begin
                        busy_cnt++;
                        if (Mem_WE !== is_wr || Mem_Addr !== addr || Mem_CE !== 1'b1) bad++;
                    end
                    tick();
                end
            end
            Mem_Ready = 1'b0;
            checks++; if (done_c != k + 1 || busy_cnt != k || bad != 0) begin
                errors++; $display("FAIL random_timing[%0d]: got done=%0d busy=%0d bad=%0d want %0d/%0d/0", i, done_c, busy_cnt, bad, k + 1, k);
            end
            checks++; if (MDR_Out !== model_mdr || Err !== tmo) begin
                errors++; $display("FAIL random_result[%0d]: got mdr=%h err=%b want %h/%b", i, MDR_Out, Err, model_mdr, tmo);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        int r_seen = 0;
        BUS_In = 16'h5555; LD_MAR = 1'b1;
        tick();
        LD_MAR = 1'b0; BUS_In = 16'h7777; LD_MDR = 1'b1;
        tick();
        LD_MDR = 1'b0; Wr_Req = 1'b1; Mem_Ready = 1'b0;
        tick();
        Wr_Req = 1'b0;
        checks++; if (Mem_CE !== 1'b1 || Mem_WE !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got ce=%b we=%b want 1/1", Mem_CE, Mem_WE);
        end
        #2 Reset = 1'b0;
        #1;
        checks++; if ({Mem_CE, Mem_WE, Busy, R, Err} !== 5'b0 || {MAR_Out, MDR_Out} !== 32'h0) begin
            errors++; $display("FAIL areset_now: got ctrl=%b regs=%h want 0/0", {Mem_CE, Mem_WE, Busy, R, Err}, {MAR_Out, MDR_Out});
        end
        for (int c = 0; c < 3; c++) begin
            if (R === 1'b1) r_seen++;
            tick();
        end
        Reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (R === 1'b1 || Busy === 1'b1) r_seen++;
            tick();
        end
        checks++; if (r_seen != 0 || MDR_Out !== 16'h0) begin
            errors++; $display("FAIL areset_after: got r_or_busy=%0d mdr=%h want 0/0", r_seen, MDR_Out);
        end
    endtask

    initial begin
        Reset = 1'b0; BUS_In = '0; LD_MAR = 1'b0; LD_MDR = 1'b0;
        Rd_Req = 1'b0; Wr_Req = 1'b0; Clr_Err = 1'b0;
        Mem_Rdata = '0; Mem_Ready = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_slow_memory();
        test_timeout();
        test_conflict();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
